mem_access: RTL

- Memory-access stage; sits between the EX/MEM pipeline register and the MEM/WB register.
- Converts a load/store from the pipeline into a request/acknowledge transaction on the data bus.
- Formats load data (lane select, sign/zero extend) onto `rdo_o`, which feeds the MEM/WB register's read-data input.
- Stalls the pipeline while a transaction is outstanding.

---
 rtl/mem_access.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Purpose  : MEM stage: turns loads/stores into a req/ack bus transaction,
//            stalls the pipeline while outstanding, formats load data.
//            Optional bus timeout enabled by defining MEM_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic [31:0] rdo_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;

  logic        w_access;
  logic        w_aligned;
  logic        w_start;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_rdata_fmt;

  always_comb begin
    w_access = valid_i & (mem_re_i | mem_we_i);
    case (size_i)
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = ~addr_i[0];
      default: w_aligned = (addr_i[1:0] == 2'b00);
    endcase
    w_start    = w_access & w_aligned & (r_state == S_IDLE);
    stall_o    = w_start | (r_state == S_REQ);
    misalign_o = w_access & ~w_aligned & (r_state == S_IDLE);

    // Store data is replicated across lanes; byte enables pick the live lane.
    case (size_i)
      2'b00: begin
        w_be    = 4'b0001 << addr_i[1:0];
        w_wdata = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << addr_i[1:0];
        w_wdata = {2{wdata_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = wdata_i;
      end
    endcase

    w_byte = bus_rdata_i[8*r_lane +: 8];
    w_half = r_lane[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (r_size)
      2'b00:   w_rdata_fmt = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_rdata_fmt = {{16{~r_unsigned & w_half[15]}}, w_half};
      default: w_rdata_fmt = bus_rdata_i;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int c_CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [c_CNT_W-1:0] r_cnt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYC;
  assign bus_err_o        = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_lane      <= 2'b00;
      rdo_o       <= 32'h0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'h0;
      bus_wdata_o <= 32'h0;
      bus_be_o    <= 4'h0;
`ifdef MEM_TIMEOUT_EN
      bus_err_o   <= 1'b0;
      r_cnt       <= '0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      bus_err_o <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state     <= S_REQ;
            r_size      <= size_i;
            r_unsigned  <= unsigned_i;
            r_lane      <= addr_i[1:0];
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_we_i;
            bus_addr_o  <= {addr_i[31:2], 2'b00};
            bus_wdata_o <= w_wdata;
            bus_be_o    <= w_be;
`ifdef MEM_TIMEOUT_EN
            r_cnt       <= '0;
`endif
          end
        end
        S_REQ: begin
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            if (!bus_we_o) begin
              rdo_o <= w_rdata_fmt;
            end
            r_state <= S_DONE;
`ifdef MEM_TIMEOUT_EN
          end else if (r_cnt == c_CNT_W'(TIMEOUT_CYC - 1)) begin
            bus_req_o <= 1'b0;
            rdo_o     <= 32'h0;
            bus_err_o <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
`endif
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
